// File: rtl/sfx_sequencer_if.sv
// Trigger/audio bundle between the Play block and the sound-effect sequencer.
// master drives the effect request, slave (the sequencer) drives the audio pins.
interface sfx_sequencer_if;
    logic [2:0] sound_code;
    logic       play_sound;
    logic       pwm;
    logic       amp_en;
    logic       busy;

    modport master (output sound_code, output play_sound, input pwm, input amp_en, input busy);
    modport slave  (input sound_code, input play_sound, output pwm, output amp_en, output busy);
endinterface

// File: rtl/sfx_sequencer.sv
// Sound-effect sequencer: plays a short ROM note sequence per code as a square wave on pwm.
// Optional SFX_QUEUE_EN adds a one-entry pending slot instead of preempting a running effect.
module sfx_sequencer #(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned NOTE_MS = 80,
    parameter int unsigned GAP_MS  = 20
) (
    input  logic           clk,
    input  logic           rstn,
    sfx_sequencer_if.slave sfx
);
    localparam int unsigned NOTE_TICKS = (CLK_HZ / 1000) * NOTE_MS;
    localparam int unsigned GAP_TICKS  = (CLK_HZ / 1000) * GAP_MS;
    localparam int unsigned TICK_MAX   = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
    localparam int unsigned TICK_W     = (TICK_MAX > 2) ? $clog2(TICK_MAX) : 1;

    localparam int unsigned HALF_F4 = CLK_HZ / (2 * 349);
    localparam int unsigned HALF_A4 = CLK_HZ / (2 * 440);
    localparam int unsigned HALF_C5 = CLK_HZ / (2 * 523);
    localparam int unsigned HALF_E5 = CLK_HZ / (2 * 659);
    localparam int unsigned HALF_G5 = CLK_HZ / (2 * 784);
    localparam int unsigned HALF_C6 = CLK_HZ / (2 * 1047);
    localparam int unsigned HALF_W  = (HALF_F4 > 2) ? $clog2(HALF_F4) : 1;

    typedef enum logic [1:0] {IDLE, TONE, GAP} state_t;
    typedef enum logic [2:0] {N_F4, N_A4, N_C5, N_E5, N_G5, N_C6} note_t;

    // Half-period counter terminal value (HALF-1) for each note.
    function automatic logic [HALF_W-1:0] half_lim_of(input note_t n);
        case (n)
            N_F4:    half_lim_of = HALF_W'(HALF_F4 - 1);
            N_A4:    half_lim_of = HALF_W'(HALF_A4 - 1);
            N_C5:    half_lim_of = HALF_W'(HALF_C5 - 1);
            N_E5:    half_lim_of = HALF_W'(HALF_E5 - 1);
            N_G5:    half_lim_of = HALF_W'(HALF_G5 - 1);
            N_C6:    half_lim_of = HALF_W'(HALF_C6 - 1);
            default: half_lim_of = HALF_W'(HALF_C5 - 1);
        endcase
    endfunction

    function automatic logic [2:0] seq_len(input logic [2:0] c);
        case (c)
            3'd1, 3'd7: seq_len = 3'd1;
            3'd2, 3'd4: seq_len = 3'd2;
            3'd3:       seq_len = 3'd3;
            3'd5, 3'd6: seq_len = 3'd4;
            default:    seq_len = 3'd0;
        endcase
    endfunction

    // Note ROM indexed by {code, note index}.
    function automatic note_t seq_note(input logic [2:0] c, input logic [1:0] i);
        case ({c, i})
            5'b001_00: seq_note = N_C5;
            5'b010_00: seq_note = N_G5;
            5'b010_01: seq_note = N_C5;
            5'b011_00: seq_note = N_C6;
            5'b011_01: seq_note = N_G5;
            5'b011_10: seq_note = N_C6;
            5'b100_00: seq_note = N_F4;
            5'b100_01: seq_note = N_F4;
            5'b101_00: seq_note = N_C5;
            5'b101_01: seq_note = N_E5;
            5'b101_10: seq_note = N_G5;
            5'b101_11: seq_note = N_C6;
            5'b110_00: seq_note = N_G5;
            5'b110_01: seq_note = N_E5;
            5'b110_10: seq_note = N_C5;
            5'b110_11: seq_note = N_F4;
            5'b111_00: seq_note = N_C6;
            default:   seq_note = N_C5;
        endcase
    endfunction

    state_t            state, state_nxt;
    logic [2:0]        code_q, code_nxt;
    logic [1:0]        idx_q, idx_nxt;
    logic [TICK_W-1:0] tick_q, tick_nxt;
    logic [HALF_W-1:0] half_q, half_nxt;
    logic              pwm_q, pwm_nxt;
    logic              busy_q, amp_q, busy_nxt;
    logic              play_q;

    logic              rise, valid_trig, tone_end, gap_end, last_note, seq_end;
    logic              load;
    logic [2:0]        load_code;
    logic [HALF_W-1:0] half_lim;

    assign rise       = sfx.play_sound & ~play_q;
    assign valid_trig = rise & (sfx.sound_code != 3'd0);
    assign tone_end   = (state == TONE) && (tick_q == TICK_W'(NOTE_TICKS - 1));
    assign gap_end    = (state == GAP)  && (tick_q == TICK_W'(GAP_TICKS - 1));
    assign last_note  = ({1'b0, idx_q} == (seq_len(code_q) - 3'd1));
    assign seq_end    = gap_end & last_note;
    assign half_lim   = half_lim_of(seq_note(code_q, idx_q));

`ifdef SFX_QUEUE_EN
    logic       pend_v;
    logic [2:0] pend_code;
    logic       trig_direct;

    // A trigger only starts directly when idle or on the very cycle the sequence ends.
    assign trig_direct = valid_trig & ((state == IDLE) | seq_end);
    assign load        = trig_direct | (seq_end & pend_v);
    assign load_code   = trig_direct ? sfx.sound_code : pend_code;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend_v    <= 1'b0;
            pend_code <= 3'd0;
        end else if (valid_trig && !trig_direct) begin
            pend_v    <= 1'b1;
            pend_code <= sfx.sound_code;
        end else if (seq_end) begin
            pend_v    <= 1'b0;
        end
    end
`else
    assign load      = valid_trig;
    assign load_code = sfx.sound_code;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            code_q <= 3'd0;
            idx_q  <= 2'd0;
            tick_q <= '0;
            half_q <= '0;
            pwm_q  <= 1'b0;
            busy_q <= 1'b0;
            amp_q  <= 1'b0;
            play_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            code_q <= code_nxt;
            idx_q  <= idx_nxt;
            tick_q <= tick_nxt;
            half_q <= half_nxt;
            pwm_q  <= pwm_nxt;
            busy_q <= busy_nxt;
            amp_q  <= busy_nxt;
            play_q <= sfx.play_sound;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = IDLE;
            TONE:    if (tone_end) state_nxt = GAP;
            GAP:     if (gap_end)  state_nxt = last_note ? IDLE : TONE;
            default: state_nxt = IDLE;
        endcase
        if (load) state_nxt = TONE;
    end

    // Counter/pwm next values; a load restarts the note engine from a clean note 0.
    always_comb begin
        code_nxt = code_q;
        idx_nxt  = idx_q;
        tick_nxt = tick_q;
        half_nxt = half_q;
        pwm_nxt  = pwm_q;
        case (state)
            TONE: begin
                if (tone_end) begin
                    tick_nxt = '0;
                    half_nxt = '0;
                    pwm_nxt  = 1'b0;
                end else begin
                    tick_nxt = tick_q + TICK_W'(1);
                    if (half_q == half_lim) begin
                        half_nxt = '0;
                        pwm_nxt  = ~pwm_q;
                    end else begin
                        half_nxt = half_q + HALF_W'(1);
                    end
                end
            end
            GAP: begin
                if (gap_end) begin
                    tick_nxt = '0;
                    half_nxt = '0;
                    pwm_nxt  = 1'b0;
                    idx_nxt  = last_note ? 2'd0 : idx_q + 2'd1;
                end else begin
                    tick_nxt = tick_q + TICK_W'(1);
                end
            end
            default: begin
                idx_nxt  = 2'd0;
                tick_nxt = '0;
                half_nxt = '0;
                pwm_nxt  = 1'b0;
            end
        endcase
        if (load) begin
            code_nxt = load_code;
            idx_nxt  = 2'd0;
            tick_nxt = '0;
            half_nxt = '0;
            pwm_nxt  = 1'b0;
        end
        busy_nxt = (state_nxt != IDLE);
    end

    assign sfx.pwm    = pwm_q;
    assign sfx.busy   = busy_q;
    assign sfx.amp_en = amp_q;
endmodule

// File: tb/tb_sfx_sequencer.sv
// Scoreboarded bench for sfx_sequencer: scenarios push expected busy segments, a monitor
// checks each segment's length, chaining and pwm waveform against an arithmetic pitch model.
module tb_sfx_sequencer;
    localparam int CLK_HZ = 1_000_000;
    localparam int NT     = 1000;
    localparam int GT     = 1000;
    localparam int PER    = NT + GT;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    sfx_sequencer_if sif();

    sfx_sequencer #(.CLK_HZ(CLK_HZ), .NOTE_MS(1), .GAP_MS(1)) dut (
        .clk  (clk),
        .rstn (rstn),
        .sfx  (sif)
    );

    typedef struct {
        int code;
        int len;
        bit cont;
    } seg_t;

    seg_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    int lens[8]     = '{0, 1, 2, 3, 2, 4, 4, 1};
    int freqs[8][4] = '{'{0, 0, 0, 0}, '{523, 0, 0, 0}, '{784, 523, 0, 0},
                        '{1047, 784, 1047, 0}, '{349, 349, 0, 0}, '{523, 659, 784, 1047},
                        '{784, 659, 523, 349}, '{1047, 0, 0, 0}};

    function automatic int full_len(input int c);
        return lens[c] * PER;
    endfunction

    // Expected pwm level at a given cycle offset into a sequence.
    function automatic logic model_pwm(input int c, input int off);
        int k, j, h;
        k = off / PER;
        j = off % PER;
        if (c < 1 || c > 7 || k >= lens[c] || j >= NT) return 1'b0;
        h = CLK_HZ / (2 * freqs[c][k]);
        return ((j / h) % 2) == 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor
    bit   active = 1'b0;
    seg_t cur;
    int   off = 0, pwm_err = 0, first_err = -1, idle_err = 0, amp_err = 0;

    task automatic close_seg(input bit still_busy);
        check($sformatf("seg_len code%0d", cur.code), 32'(off), 32'(cur.len));
        check($sformatf("seg_chain code%0d", cur.code), 32'(still_busy), 32'(cur.cont));
        check($sformatf("seg_pwm_errors code%0d first_at%0d", cur.code, first_err), 32'(pwm_err), 32'd0);
    endtask

    always @(negedge clk) begin
        if (sif.amp_en !== sif.busy) amp_err++;
        if (sif.busy === 1'b1) begin
            if (active && off == cur.len) begin
                close_seg(1'b1);
                active = 1'b0;
            end
            if (!active) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_start: busy=1 expected 0");
                    cur.code = 0;
                    cur.len  = -1;
                    cur.cont = 1'b0;
                end else begin
                    cur = sb.pop_front();
                end
                active    = 1'b1;
                off       = 0;
                pwm_err   = 0;
                first_err = -1;
            end
            if (cur.code != 0 && sif.pwm !== model_pwm(cur.code, off)) begin
                if (pwm_err == 0) first_err = off;
                pwm_err++;
            end
            off++;
        end else begin
            if (sif.pwm !== 1'b0) idle_err++;
            if (active) begin
                close_seg(1'b0);
                active = 1'b0;
            end
        end
    end

    // Driver: t_rel counts negedges since scenario start; inputs change 1 time unit after a negedge.
    int t_rel = 0;

    task automatic go_to(input int d);
        if (d > t_rel) begin
            repeat (d - t_rel) @(negedge clk);
            #1;
        end
        t_rel = d;
    endtask

    task automatic start_scn();
        @(negedge clk);
        #1;
        t_rel = 0;
    endtask

    task automatic trig_at(input int d, input int c, input int hold = 1);
        go_to(d);
        sif.sound_code = 3'(c);
        sif.play_sound = 1'b1;
        go_to(d + hold);
        sif.play_sound = 1'b0;
        sif.sound_code = 3'($urandom_range(7, 0));
    endtask

    task automatic push(input int c, input int l, input bit cont);
        seg_t s;
        s.code = c;
        s.len  = l;
        s.cont = cont;
        sb.push_back(s);
    endtask

    task automatic do_reset(input int r);
        go_to(r);
        rstn = 1'b0;
        #1;
        check("midrun_rst_busy", 32'(sif.busy), 32'd0);
        check("midrun_rst_pwm", 32'(sif.pwm), 32'd0);
        check("midrun_rst_amp_en", 32'(sif.amp_en), 32'd0);
        go_to(r + 3);
        rstn = 1'b1;
    endtask

    // kind 0: single effect; 1: second trigger (code b) at offset d; 2: reset at offset d.
    task automatic run_scn(input int a, input int kind, input int d, input int b);
        int fa, fb, span;
        fa = full_len(a);
        fb = full_len(b);
        span = fa;
        if (kind == 0) begin
            push(a, fa, 1'b0);
        end else if (kind == 1) begin
            if (b == 0) begin
                push(a, fa, 1'b0);
            end else begin
`ifdef SFX_QUEUE_EN
                if (d < fa) begin
                    push(a, fa, 1'b1);
                    span = fa + fb;
                end else begin
                    push(a, d, 1'b1);
                    span = d + fb;
                end
`else
                push(a, d, 1'b1);
                span = d + fb;
`endif
                push(b, fb, 1'b0);
            end
        end else begin
            push(a, d, 1'b0);
            span = d;
        end
        start_scn();
        trig_at(0, a);
        if (kind == 1) trig_at(d, b);
        if (kind == 2) do_reset(d);
        go_to(span + 12);
    endtask

    initial begin
        int a, kind, b, d;
        sif.sound_code = 3'd0;
        sif.play_sound = 1'b0;
        rstn = 1'b1;
        #2 rstn = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_pwm", 32'(sif.pwm), 32'd0);
        check("reset_busy", 32'(sif.busy), 32'd0);
        check("reset_amp_en", 32'(sif.amp_en), 32'd0);
        #1 rstn = 1'b1;
        repeat (5) @(negedge clk);
        check("post_reset_busy", 32'(sif.busy), 32'd0);
        check("post_reset_pwm", 32'(sif.pwm), 32'd0);

        run_scn(1, 0, 0, 0);
        run_scn(5, 0, 0, 0);

        // Code 0 must not start anything.
        start_scn();
        trig_at(0, 0);
        go_to(50);

        // Held trigger plays exactly once.
        push(7, 2000, 1'b0);
        start_scn();
        trig_at(0, 7, 5000);
        go_to(5012);

        run_scn(6, 1, 500, 2);
        run_scn(7, 1, 2000, 1);
        run_scn(4, 1, 700, 0);

        // Three triggers in a row: preempt twice, or last pending code wins.
`ifdef SFX_QUEUE_EN
        push(1, 2000, 1'b1);
        push(7, 2000, 1'b0);
`else
        push(1, 300, 1'b1);
        push(3, 300, 1'b1);
        push(7, 2000, 1'b0);
`endif
        start_scn();
        trig_at(0, 1);
        trig_at(300, 3);
        trig_at(600, 7);
        go_to(4012);

        // Reset after a second trigger: nothing may resume afterwards.
`ifdef SFX_QUEUE_EN
        push(1, 800, 1'b0);
`else
        push(1, 500, 1'b1);
        push(3, 300, 1'b0);
`endif
        start_scn();
        trig_at(0, 1);
        trig_at(500, 3);
        do_reset(800);
        go_to(2500);

        run_scn(5, 2, 3000, 0);

        for (int i = 0; i < 4; i++) begin
            a    = int'($urandom_range(7, 1));
            kind = int'($urandom_range(2, 0));
            b    = int'($urandom_range(7, 0));
            if (kind == 1) d = int'($urandom_range(full_len(a), 2));
            else           d = int'($urandom_range(full_len(a) - 1, 1));
            run_scn(a, kind, d, b);
        end

        go_to(t_rel + 10);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        check("idle_at_end", 32'(active), 32'd0);
        check("pwm_outside_busy", 32'(idle_err), 32'd0);
        check("amp_en_vs_busy", 32'(amp_err), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
